// File: rtl/instr_encoder.sv
// RV32I field-to-word encoder: packs decoded fields into instruction words, tags each
// with an incrementing byte address and queues them in a small FIFO for the memory writer.
`ifndef OPWIDTH
`define OPWIDTH 7
`endif
`ifndef REGWIDTH
`define REGWIDTH 32
`endif

module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restart,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [`OPWIDTH-1:0]  opcode,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic [4:0]           rd,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  logic [`REGWIDTH-1:0] imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [`REGWIDTH-1:0] out_instr,
  output logic [`REGWIDTH-1:0] out_addr,
  output logic                 err_illegal,
  output logic                 err_align,
  output logic [7:0]           drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpIarith = 7'b0010011;
  localparam logic [6:0] OpIload  = 7'b0000011;
  localparam logic [6:0] OpStype  = 7'b0100011;
  localparam logic [6:0] OpBtype  = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  logic [31:0] enc;
  logic        legal;
  logic        misalign;

  always_comb begin
    enc      = '0;
    legal    = 1'b1;
    misalign = 1'b0;
    case (opcode)
      OpRtype:          enc = {funct7, rs2, rs1, funct3, rd, opcode};
      OpIarith, OpIload: enc = {imm[11:0], rs1, funct3, rd, opcode};
      OpJalr:           enc = {imm[11:0], rs1, 3'b000, rd, opcode};
      OpStype:          enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      OpBtype: begin
        enc      = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        misalign = imm[0];
      end
      OpJal: begin
        enc      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        misalign = imm[0];
      end
      OpLui, OpAuipc:   enc = {imm[31:12], rd, opcode};
      default:          legal = 1'b0;
    endcase
  end

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] addr_mem  [DEPTH];
  logic [AW:0] wptr, rptr, wptr_d, rptr_d;
  logic [31:0] addr;
  logic        accept, pop, write, full_d;

  assign accept    = in_valid && in_ready;
  assign out_valid = (wptr != rptr);
  assign pop       = out_valid && out_ready;
  assign write     = accept && legal && !misalign;
  assign wptr_d    = write ? wptr + (AW+1)'(1) : wptr;
  assign rptr_d    = pop ? rptr + (AW+1)'(1) : rptr;
  assign full_d    = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);

  // Empty FIFO presents zeros so reset/flush leave a clean bus.
  assign out_instr = out_valid ? instr_mem[rptr[AW-1:0]] : '0;
  assign out_addr  = out_valid ? addr_mem[rptr[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (write && rst && !restart) begin
      instr_mem[wptr[AW-1:0]] <= enc;
      addr_mem[wptr[AW-1:0]]  <= addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr        <= '0;
      rptr        <= '0;
      addr        <= BASE_ADDR;
      in_ready    <= 1'b0;
      err_illegal <= 1'b0;
      err_align   <= 1'b0;
      drop_cnt    <= '0;
    end else if (restart) begin
      wptr     <= '0;
      rptr     <= '0;
      addr     <= BASE_ADDR;
      in_ready <= 1'b1;
    end else begin
      wptr     <= wptr_d;
      rptr     <= rptr_d;
      in_ready <= !full_d;
      if (write) addr <= addr + 32'd4;
      if (accept && !legal) err_illegal <= 1'b1;
      if (accept && legal && misalign) err_align <= 1'b1;
      if (accept && !(legal && !misalign) && drop_cnt != 8'd255) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder: encodings, addresses, backpressure,
// error drops, restart and mid-stream reset.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst, restart, in_valid, in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_addr;
  logic        err_illegal, err_align;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad   = 0;
  int acc;

  instr_encoder #(.BASE_ADDR(32'h0), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .restart(restart), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .err_illegal(err_illegal), .err_align(err_align),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                            input logic [31:0] im);
    opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic push(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [31:0] im);
    bit done = 0;
    set_fields(op, f3, f7, d, s1, s2, im);
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_word(input string tag, input logic [31:0] ins, input logic [31:0] ad);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_instr"}, out_instr, ins);
    check({tag, "_addr"}, out_addr, ad);
  endtask

  initial begin
    rst = 1'b0; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_fields(7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    @(negedge clk); @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_addr", out_addr, 32'd0);
    check("rst_errs", {30'd0, err_illegal, err_align}, 32'd0);
    check("rst_drop", {24'd0, drop_cnt}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic encodings, consumer always ready
    push(7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    expect_word("addi", 32'h00500093, 32'h0);
    push(7'b0110011, 3'b000, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    expect_word("add", 32'h002081B3, 32'h4);
    push(7'b0100011, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    expect_word("sw", 32'h0020A423, 32'h8);
    push(7'b1100011, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
    expect_word("beq", 32'hFE000EE3, 32'hC);
    push(7'b1101111, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8);
    expect_word("jal", 32'h008000EF, 32'h10);
    push(7'b0110111, 3'b000, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
    expect_word("lui", 32'h123452B7, 32'h14);
    push(7'b1100111, 3'b101, 7'd0, 5'd1, 5'd2, 5'd0, 32'h10);
    expect_word("jalr", 32'h010100E7, 32'h18);
    push(7'b0010111, 3'b000, 7'd0, 5'd2, 5'd0, 5'd0, 32'hFFFF_F123);
    expect_word("auipc", 32'hFFFFF117, 32'h1C);
    push(7'b0010011, 3'b101, 7'd0, 5'd1, 5'd2, 5'd0, 32'h403);
    expect_word("srai", 32'h40315093, 32'h20);
    push(7'b0000011, 3'b010, 7'd0, 5'd4, 5'd3, 5'd0, 32'hFFFF_FFF8);
    expect_word("lw", 32'hFF81A203, 32'h24);
    @(negedge clk);
    check("drained", {31'd0, out_valid}, 32'd0);

    // Restart to realign addresses, then backpressure
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      set_fields(7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'(i + 1));
      in_valid = 1'b1;
      if (in_ready) acc++;
      @(negedge clk);
      if (i == 3) check("bp_ready_low", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    check("bp_accepted", 32'(acc), 32'd4);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expect_word("bp_word", 32'h00000093 | (32'(k + 1) << 20), 32'(4 * k));
      @(negedge clk);
    end
    check("bp_empty", {31'd0, out_valid}, 32'd0);
    check("bp_ready_back", {31'd0, in_ready}, 32'd1);

    // Error drops
    push(7'b1111111, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
    check("ill_no_out", {31'd0, out_valid}, 32'd0);
    check("ill_flag", {31'd0, err_illegal}, 32'd1);
    check("ill_drop", {24'd0, drop_cnt}, 32'd1);
    push(7'b1100011, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3);
    check("align_no_out", {31'd0, out_valid}, 32'd0);
    check("align_flag", {31'd0, err_align}, 32'd1);
    check("align_drop", {24'd0, drop_cnt}, 32'd2);
    push(7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    expect_word("post_err", 32'h00500093, 32'h10);
    @(negedge clk);

    // Restart with 3 queued and a simultaneous accept
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) push(7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd7);
    check("rs_queued_addr", out_addr, 32'h14);
    set_fields(7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd9);
    in_valid = 1'b1; restart = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; restart = 1'b0;
    check("rs_empty", {31'd0, out_valid}, 32'd0);
    check("rs_errs_kept", {30'd0, err_illegal, err_align}, 32'd3);
    check("rs_drop_kept", {24'd0, drop_cnt}, 32'd2);
    push(7'b0110011, 3'b000, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    expect_word("rs_first", 32'h002081B3, 32'h0);
    @(negedge clk);

    // Mid-stream reset with a full FIFO
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) push(7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
    check("full_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_in_ready", {31'd0, in_ready}, 32'd0);
    check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_out_instr", out_instr, 32'd0);
    check("mrst_out_addr", out_addr, 32'd0);
    check("mrst_errs", {30'd0, err_illegal, err_align}, 32'd0);
    check("mrst_drop", {24'd0, drop_cnt}, 32'd0);
    rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("mrst_rel_ready", {31'd0, in_ready}, 32'd1);
    push(7'b0100011, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    expect_word("mrst_first", 32'h0020A423, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
